rcb_reg_bus_arbiter: RTL and testbench
======================================

// Module: rcb_reg_bus_arbiter
// PURPOSE
//  Shares one internal register bus between the SPI slave internal interface and one local FPGA requester.
//  Turns SPI addr/data strobes into bus read/write cycles, returns read data on data_miso, and serialises local accesses.
//  SPI always has priority. Sits between the SPI slave and the register bank/decoders.
// PARAMETERS
//  ACK_TIMEOUT  8            clk_100m cycles to wait for bus_ack before the access is forced to complete
//  TO_RDATA     32'hDEADBEEF read data returned on timeout
// PORTS
//  clk_100m       in   1   system clock
//  rst_n_syn      in   1   asynchronous reset, active low
//  spi_addr       in   16  address from SPI slave, valid when spi_addr_rdy=1
//  spi_addr_rdy   in   1   1-cycle strobe: address phase done
//  spi_wdata      in   32  write data from SPI slave (data_mosi)
//  spi_wdata_rdy  in   1   1-cycle strobe: write data valid (data_mosi_rdy)
//  spi_rd_done    in   1   1-cycle strobe: SPI read frame finished (data_miso_rdy)
//  spi_rdata      out  32  read data to SPI slave (data_miso)
//  loc_req        in   1   local access request, held until loc_done
//  loc_we         in   1   1=write, 0=read; stable while loc_req=1
//  loc_addr       in   16  local address
//  loc_wdata      in   32  local write data
//  loc_done       out  1   1-cycle strobe: local access complete
//  loc_rdata      out  32  local read data, valid with loc_done
//  bus_addr       out  16  register bus address
//  bus_wdata      out  32  register bus write data
//  bus_we         out  1   write strobe, held until ack/timeout
//  bus_re         out  1   read strobe, held until ack/timeout
//  bus_rdata      in   32  register bus read data, valid with bus_ack
//  bus_ack        in   1   access acknowledge
//  bus_timeout    out  1   1-cycle strobe: access completed by timeout
//  err_cnt        out  16  timeout counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: FSM=IDLE; bus_we=bus_re=loc_done=bus_timeout=0; bus_addr=16'hFFFF; bus_wdata=0;
//    spi_rdata=0; loc_rdata=0; err_cnt=0; pend_rd=pend_wr=0; spi_addr_lat=16'hFFFF.
//  - spi_addr_rdy: latch spi_addr into spi_addr_lat and set pend_rd (speculative read; register reads are side-effect free).
//  - spi_wdata_rdy: set pend_wr and latch spi_wdata. Strobes are captured in any state; none is lost.
//  - FSM states: IDLE, SPI_RD, SPI_WR, LOC_RD, LOC_WR.
//    Priority in IDLE: pend_wr > pend_rd > loc_req.
//    pend_wr wins because it completes an earlier frame; the read of the next frame starts after it.
//  - On entering an access state: drive bus_addr/bus_wdata and assert bus_re or bus_we the next cycle; clear the matching pend flag.
//  - Leave on bus_ack, or when the wait counter reaches ACK_TIMEOUT-1. Return to IDLE.
//    Timeout: pulse bus_timeout; read data = TO_RDATA.
//  - SPI_RD completion: spi_rdata <= bus_rdata (or TO_RDATA). Held until the next SPI read completes.
//    Worst case spi_addr_rdy -> spi_rdata valid: 2*(ACK_TIMEOUT+2) cycles (one local access in flight plus own access).
//    System constraint: this must be shorter than half an SCLK period.
//  - LOC_* completion: loc_done=1 for 1 cycle; loc_rdata updated on reads only.
//    loc_req must deassert the cycle after loc_done, otherwise it is re-arbitrated.
//  - A local access in flight is never aborted. SPI strobes wait in pend_* until it ends.
//  - Same-cycle spi_addr_rdy and spi_wdata_rdy: both flags set; the write is issued first.
//  - A repeated spi_addr_rdy while pend_rd=1 overwrites spi_addr_lat. Last address wins, one read only.
//  - spi_rd_done: clears pend_rd if the read has not started. Otherwise informational only.
//  - bus_ack outside an access state is ignored. bus_we and bus_re are never both 1.
//  - Reset mid-access: all strobes drop immediately (async); pending flags are cleared.
// CONFIGURATION
//  RCB_ARB_TIMEOUT_CNT_EN defined: err_cnt increments on each bus_timeout, saturates at 16'hFFFF, cleared only by reset.
//  Not defined: err_cnt tied to 16'h0 and no counter logic is built.
//  Timeout behaviour is identical in both cases.
// TESTING
//  1 SPI write: addr_rdy(0x0010), 40 cycles later wdata_rdy(0x12345678), ack after 2 cycles
//    -> speculative bus_re@0x0010, then bus_we@0x0010 data 0x12345678.
//  2 SPI read: addr_rdy(0x0020), bus_rdata=0xCAFEF00D with ack after 3 cycles
//    -> spi_rdata=0xCAFEF00D within 5 cycles of the strobe.
//  3 Contention: loc_req read@0x0030 in flight, addr_rdy(0x0040) arrives
//    -> local completes with loc_done, then bus_re@0x0040 next, loc_req not re-granted before it.
//  4 Timeout: no bus_ack on SPI read -> bus_timeout after 8 cycles, spi_rdata=0xDEADBEEF;
//    err_cnt=1 with macro defined, 0 without.
//  5 Same-cycle addr_rdy(0x0050) + wdata_rdy(0xA5A5A5A5) -> write issued first, then read@0x0050.
//  6 Reset asserted during bus_we -> bus_we=0, pend flags cleared, FSM IDLE, spi_rdata=0.

Source files
------------

// File: rtl/rcb_reg_bus_arbiter_if.sv
// Signal bundle around rcb_reg_bus_arbiter: SPI slave internal interface,
// local FPGA requester and the shared register bus.
// The arbiter connects through the master modport. Its environment (the SPI
// slave, the local requester and the register bank, or a bench) uses the
// slave modport.
interface rcb_reg_bus_arbiter_if;

    // SPI slave internal interface
    logic [15:0] spi_addr;
    logic        spi_addr_rdy;
    logic [31:0] spi_wdata;
    logic        spi_wdata_rdy;
    logic        spi_rd_done;
    logic [31:0] spi_rdata;

    // Local requester
    logic        loc_req;
    logic        loc_we;
    logic [15:0] loc_addr;
    logic [31:0] loc_wdata;
    logic        loc_done;
    logic [31:0] loc_rdata;

    // Register bus and status
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_timeout;
    logic [15:0] err_cnt;

    modport master (
        input  spi_addr, spi_addr_rdy, spi_wdata, spi_wdata_rdy, spi_rd_done,
        output spi_rdata,
        input  loc_req, loc_we, loc_addr, loc_wdata,
        output loc_done, loc_rdata,
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_ack,
        output bus_timeout, err_cnt
    );

    modport slave (
        output spi_addr, spi_addr_rdy, spi_wdata, spi_wdata_rdy, spi_rd_done,
        input  spi_rdata,
        output loc_req, loc_we, loc_addr, loc_wdata,
        input  loc_done, loc_rdata,
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_ack,
        input  bus_timeout, err_cnt
    );

endinterface

// File: rtl/rcb_reg_bus_arbiter.sv
// rcb_reg_bus_arbiter: shares one internal register bus between the SPI slave
// and one local requester. SPI address strobes start a speculative read
// (register reads are side-effect free). SPI write data strobes start a write
// to the last latched address. SPI always beats the local requester, but an
// access already on the bus is never aborted.
//
// Optional feature: define RCB_ARB_TIMEOUT_CNT_EN to build a saturating
// timeout counter on err_cnt. Without it err_cnt is tied to zero.
module rcb_reg_bus_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter logic [31:0] TO_RDATA    = 32'hDEADBEEF
) (
    input  logic                         clk_100m,
    input  logic                         rst_n_syn,
    rcb_reg_bus_arbiter_if.master        arb
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPI_RD,
        ST_SPI_WR,
        ST_LOC_RD,
        ST_LOC_WR
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              pend_rd_q, pend_rd_d;
    logic              pend_wr_q, pend_wr_d;
    logic [15:0]       spi_addr_lat_q, spi_addr_lat_d;
    logic [31:0]       spi_wdata_lat_q, spi_wdata_lat_d;

    logic [15:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              bus_we_q, bus_we_d;
    logic              bus_re_q, bus_re_d;
    logic              bus_timeout_q, bus_timeout_d;
    logic [31:0]       spi_rdata_q, spi_rdata_d;
    logic              loc_done_q, loc_done_d;
    logic [31:0]       loc_rdata_q, loc_rdata_d;

    logic              grant_rd;
    logic              grant_wr;
    logic              in_access;
    logic              ack_hit;
    logic              to_hit;
    logic [31:0]       rd_val;

    // An ack only counts while an access is on the bus. The timeout fires in
    // the last allowed wait cycle, so a strobe is held ACK_TIMEOUT cycles.
    assign in_access = (state_q != ST_IDLE);
    assign ack_hit   = in_access && arb.bus_ack;
    assign to_hit    = in_access && !arb.bus_ack && (wait_cnt_q == CNT_LAST);
    assign rd_val    = ack_hit ? arb.bus_rdata : TO_RDATA;

    // Arbitration, access sequencing and registered bus/response outputs.
    always_comb begin
        // NOTE: every variable gets its hold/idle value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_we_d      = bus_we_q;
        bus_re_d      = bus_re_q;
        bus_timeout_d = 1'b0;
        loc_done_d    = 1'b0;
        spi_rdata_d   = spi_rdata_q;
        loc_rdata_d   = loc_rdata_q;
        grant_rd      = 1'b0;
        grant_wr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                // A pending write finishes an earlier frame, so it goes before
                // the speculative read of the next one.
                if (pend_wr_q) begin
                    state_d     = ST_SPI_WR;
                    bus_addr_d  = spi_addr_lat_q;
                    bus_wdata_d = spi_wdata_lat_q;
                    bus_we_d    = 1'b1;
                    grant_wr    = 1'b1;
                end else if (pend_rd_q) begin
                    state_d    = ST_SPI_RD;
                    bus_addr_d = spi_addr_lat_q;
                    bus_re_d   = 1'b1;
                    grant_rd   = 1'b1;
                end else if (arb.loc_req && !loc_done_q) begin
                    // The requester still holds loc_req while it sees
                    // loc_done, so that cycle must not start a new access.
                    bus_addr_d = arb.loc_addr;
                    if (arb.loc_we) begin
                        state_d     = ST_LOC_WR;
                        bus_wdata_d = arb.loc_wdata;
                        bus_we_d    = 1'b1;
                    end else begin
                        state_d  = ST_LOC_RD;
                        bus_re_d = 1'b1;
                    end
                end
            end

            ST_SPI_RD,
            ST_SPI_WR,
            ST_LOC_RD,
            ST_LOC_WR: begin
                if (ack_hit || to_hit) begin
                    state_d       = ST_IDLE;
                    bus_we_d      = 1'b0;
                    bus_re_d      = 1'b0;
                    bus_timeout_d = to_hit;
                    if (state_q == ST_SPI_RD) begin
                        spi_rdata_d = rd_val;
                    end
                    if (state_q == ST_LOC_RD) begin
                        loc_rdata_d = rd_val;
                    end
                    if ((state_q == ST_LOC_RD) || (state_q == ST_LOC_WR)) begin
                        loc_done_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                bus_we_d = 1'b0;
                bus_re_d = 1'b0;
            end
        endcase
    end

    // SPI strobe capture. A new strobe beats a same-cycle grant or cancel, so
    // no strobe is ever lost. A repeated address simply overwrites the latch.
    always_comb begin
        pend_rd_d       = pend_rd_q;
        pend_wr_d       = pend_wr_q;
        spi_addr_lat_d  = spi_addr_lat_q;
        spi_wdata_lat_d = spi_wdata_lat_q;

        // spi_rd_done only matters while the read is still waiting.
        if (grant_rd || arb.spi_rd_done) begin
            pend_rd_d = 1'b0;
        end
        if (arb.spi_addr_rdy) begin
            pend_rd_d      = 1'b1;
            spi_addr_lat_d = arb.spi_addr;
        end

        if (grant_wr) begin
            pend_wr_d = 1'b0;
        end
        if (arb.spi_wdata_rdy) begin
            pend_wr_d       = 1'b1;
            spi_wdata_lat_d = arb.spi_wdata;
        end
    end

    // State, pending-strobe and output registers. Reset drops all strobes at once.
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            state_q         <= ST_IDLE;
            wait_cnt_q      <= '0;
            pend_rd_q       <= 1'b0;
            pend_wr_q       <= 1'b0;
            spi_addr_lat_q  <= 16'hFFFF;
            spi_wdata_lat_q <= '0;
            bus_addr_q      <= 16'hFFFF;
            bus_wdata_q     <= '0;
            bus_we_q        <= 1'b0;
            bus_re_q        <= 1'b0;
            bus_timeout_q   <= 1'b0;
            spi_rdata_q     <= '0;
            loc_done_q      <= 1'b0;
            loc_rdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            pend_rd_q       <= pend_rd_d;
            pend_wr_q       <= pend_wr_d;
            spi_addr_lat_q  <= spi_addr_lat_d;
            spi_wdata_lat_q <= spi_wdata_lat_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_we_q        <= bus_we_d;
            bus_re_q        <= bus_re_d;
            bus_timeout_q   <= bus_timeout_d;
            spi_rdata_q     <= spi_rdata_d;
            loc_done_q      <= loc_done_d;
            loc_rdata_q     <= loc_rdata_d;
        end
    end

`ifdef RCB_ARB_TIMEOUT_CNT_EN
    logic [15:0] err_cnt_q;

    // Count completed timeouts, saturating. Only reset clears it.
    always_ff @(posedge clk_100m or negedge rst_n_syn) begin
        if (!rst_n_syn) begin
            err_cnt_q <= '0;
        end else if (bus_timeout_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign arb.err_cnt = err_cnt_q;
`else
    assign arb.err_cnt = 16'h0;
`endif

    assign arb.bus_addr    = bus_addr_q;
    assign arb.bus_wdata   = bus_wdata_q;
    assign arb.bus_we      = bus_we_q;
    assign arb.bus_re      = bus_re_q;
    assign arb.bus_timeout = bus_timeout_q;
    assign arb.spi_rdata   = spi_rdata_q;
    assign arb.loc_done    = loc_done_q;
    assign arb.loc_rdata   = loc_rdata_q;

endmodule

// File: tb/tb_rcb_reg_bus_arbiter.sv
// Directed bench for rcb_reg_bus_arbiter: SPI write/read, SPI vs local
// contention, timeout, same-cycle strobes, address overwrite, read cancel,
// local write and reset during an access.
module tb_rcb_reg_bus_arbiter;

    logic clk_100m  = 1'b0;
    logic rst_n_syn = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;

`ifdef RCB_ARB_TIMEOUT_CNT_EN
    localparam logic [15:0] EXP_ERR_AFTER_TO = 16'd1;
`else
    localparam logic [15:0] EXP_ERR_AFTER_TO = 16'd0;
`endif

    rcb_reg_bus_arbiter_if arb_if ();

    rcb_reg_bus_arbiter #(
        .ACK_TIMEOUT (8),
        .TO_RDATA    (32'hDEADBEEF)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_n_syn (rst_n_syn),
        .arb       (arb_if)
    );

    always #5 clk_100m = ~clk_100m;

    always @(posedge clk_100m) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write and read strobes must never overlap.
    always @(negedge clk_100m) begin
        if (rst_n_syn) begin
            check("we_re_exclusive", {31'b0, arb_if.bus_we & arb_if.bus_re}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    task automatic strobe_addr(input logic [15:0] a);
        arb_if.spi_addr     = a;
        arb_if.spi_addr_rdy = 1'b1;
        tick();
        arb_if.spi_addr_rdy = 1'b0;
    endtask

    task automatic strobe_wdata(input logic [31:0] d);
        arb_if.spi_wdata     = d;
        arb_if.spi_wdata_rdy = 1'b1;
        tick();
        arb_if.spi_wdata_rdy = 1'b0;
    endtask

    task automatic wait_strobe(output logic found);
        int n = 0;
        while (!(arb_if.bus_re || arb_if.bus_we) && n < 30) begin
            tick();
            n++;
        end
        found = arb_if.bus_re || arb_if.bus_we;
    endtask

    // Wait for an access, check it, then ack after ack_delay strobe cycles.
    task automatic serve(input string tag, input logic exp_we, input logic [15:0] exp_addr,
                         input logic [31:0] exp_wdata, input int ack_delay,
                         input logic [31:0] rdata);
        logic found;
        wait_strobe(found);
        check({tag, " strobe"}, {31'b0, found}, 32'h1);
        check({tag, " we"}, {31'b0, arb_if.bus_we}, {31'b0, exp_we});
        check({tag, " re"}, {31'b0, arb_if.bus_re}, {31'b0, ~exp_we});
        check({tag, " addr"}, {16'b0, arb_if.bus_addr}, {16'b0, exp_addr});
        if (exp_we) begin
            check({tag, " wdata"}, arb_if.bus_wdata, exp_wdata);
        end
        repeat (ack_delay - 1) tick();
        arb_if.bus_rdata = rdata;
        arb_if.bus_ack   = 1'b1;
        tick();
        arb_if.bus_ack   = 1'b0;
        arb_if.bus_rdata = '0;
        check({tag, " strobe drop"}, {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   n;
        int   t0;

        arb_if.spi_addr      = '0;
        arb_if.spi_addr_rdy  = 1'b0;
        arb_if.spi_wdata     = '0;
        arb_if.spi_wdata_rdy = 1'b0;
        arb_if.spi_rd_done   = 1'b0;
        arb_if.loc_req       = 1'b0;
        arb_if.loc_we        = 1'b0;
        arb_if.loc_addr      = '0;
        arb_if.loc_wdata     = '0;
        arb_if.bus_rdata     = '0;
        arb_if.bus_ack       = 1'b0;

        // Reset values
        repeat (3) @(posedge clk_100m);
        #1;
        check("rst bus_addr", {16'b0, arb_if.bus_addr}, 32'h0000FFFF);
        check("rst bus_wdata", arb_if.bus_wdata, 32'h0);
        check("rst strobes", {28'b0, arb_if.bus_we, arb_if.bus_re, arb_if.bus_timeout, arb_if.loc_done}, 32'h0);
        check("rst spi_rdata", arb_if.spi_rdata, 32'h0);
        check("rst loc_rdata", arb_if.loc_rdata, 32'h0);
        check("rst err_cnt", {16'b0, arb_if.err_cnt}, 32'h0);
        rst_n_syn = 1'b1;
        tick();
        tick();
        check("idle no access", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);

        // 1: SPI write frame, speculative read first
        strobe_addr(16'h0010);
        serve("t1 spec rd", 1'b0, 16'h0010, 32'h0, 2, 32'h11111111);
        check("t1 spi_rdata", arb_if.spi_rdata, 32'h11111111);
        repeat (40) tick();
        strobe_wdata(32'h12345678);
        serve("t1 wr", 1'b1, 16'h0010, 32'h12345678, 2, 32'h0);
        check("t1 spi_rdata kept", arb_if.spi_rdata, 32'h11111111);
        check("t1 no loc_done", {31'b0, arb_if.loc_done}, 32'h0);

        // 2: SPI read with latency bound
        strobe_addr(16'h0020);
        t0 = cyc;
        serve("t2 rd", 1'b0, 16'h0020, 32'h0, 3, 32'hCAFEF00D);
        check("t2 spi_rdata", arb_if.spi_rdata, 32'hCAFEF00D);
        check("t2 latency<=5", {31'b0, (cyc - t0) <= 5}, 32'h1);

        // 3: SPI read arrives while a local read is on the bus
        arb_if.loc_we   = 1'b0;
        arb_if.loc_addr = 16'h0030;
        arb_if.loc_req  = 1'b1;
        wait_strobe(found);
        check("t3 loc strobe", {31'b0, found}, 32'h1);
        check("t3 loc re", {31'b0, arb_if.bus_re}, 32'h1);
        check("t3 loc addr", {16'b0, arb_if.bus_addr}, 32'h00000030);
        strobe_addr(16'h0040);
        tick();
        check("t3 loc not aborted", {16'b0, arb_if.bus_addr}, 32'h00000030);
        arb_if.bus_rdata = 32'h30303030;
        arb_if.bus_ack   = 1'b1;
        tick();
        arb_if.bus_ack   = 1'b0;
        arb_if.bus_rdata = '0;
        check("t3 loc_done", {31'b0, arb_if.loc_done}, 32'h1);
        check("t3 loc_rdata", arb_if.loc_rdata, 32'h30303030);
        tick();
        check("t3 spi re next", {31'b0, arb_if.bus_re}, 32'h1);
        check("t3 spi addr next", {16'b0, arb_if.bus_addr}, 32'h00000040);
        check("t3 loc_done 1 cycle", {31'b0, arb_if.loc_done}, 32'h0);
        arb_if.loc_req = 1'b0;
        serve("t3 spi rd", 1'b0, 16'h0040, 32'h0, 1, 32'h40404040);
        check("t3 spi_rdata", arb_if.spi_rdata, 32'h40404040);
        repeat (3) tick();
        check("t3 no regrant", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);

        // 4: SPI read timeout
        strobe_addr(16'h0060);
        wait_strobe(found);
        check("t4 strobe", {31'b0, found}, 32'h1);
        n = 0;
        while (!arb_if.bus_timeout && n < 20) begin
            tick();
            n++;
        end
        check("t4 cycles to timeout", n, 32'd8);
        check("t4 bus_timeout", {31'b0, arb_if.bus_timeout}, 32'h1);
        check("t4 re dropped", {31'b0, arb_if.bus_re}, 32'h0);
        check("t4 spi_rdata", arb_if.spi_rdata, 32'hDEADBEEF);
        tick();
        check("t4 timeout 1 cycle", {31'b0, arb_if.bus_timeout}, 32'h0);
        check("t4 err_cnt", {16'b0, arb_if.err_cnt}, {16'b0, EXP_ERR_AFTER_TO});

        // 5: same-cycle address and write data, write goes first
        arb_if.spi_addr      = 16'h0050;
        arb_if.spi_addr_rdy  = 1'b1;
        arb_if.spi_wdata     = 32'hA5A5A5A5;
        arb_if.spi_wdata_rdy = 1'b1;
        tick();
        arb_if.spi_addr_rdy  = 1'b0;
        arb_if.spi_wdata_rdy = 1'b0;
        serve("t5 wr", 1'b1, 16'h0050, 32'hA5A5A5A5, 1, 32'h0);
        serve("t5 rd", 1'b0, 16'h0050, 32'h0, 1, 32'h55555555);
        check("t5 spi_rdata", arb_if.spi_rdata, 32'h55555555);

        // 7: local write, loc_req held through the loc_done cycle
        arb_if.loc_we    = 1'b1;
        arb_if.loc_addr  = 16'h0031;
        arb_if.loc_wdata = 32'h0BADF00D;
        arb_if.loc_req   = 1'b1;
        serve("t7 loc wr", 1'b1, 16'h0031, 32'h0BADF00D, 2, 32'h0);
        check("t7 loc_done", {31'b0, arb_if.loc_done}, 32'h1);
        check("t7 loc_rdata kept", arb_if.loc_rdata, 32'h30303030);
        tick();
        arb_if.loc_req = 1'b0;
        check("t7 no regrant in done cycle", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);
        tick();

        // 8: repeated address while pending, last one wins, single read
        arb_if.loc_we   = 1'b0;
        arb_if.loc_addr = 16'h0032;
        arb_if.loc_req  = 1'b1;
        wait_strobe(found);
        check("t8 loc strobe", {31'b0, found}, 32'h1);
        strobe_addr(16'h0080);
        strobe_addr(16'h0081);
        arb_if.bus_rdata = 32'h32323232;
        arb_if.bus_ack   = 1'b1;
        tick();
        arb_if.bus_ack   = 1'b0;
        arb_if.bus_rdata = '0;
        arb_if.loc_req   = 1'b0;
        check("t8 loc_rdata", arb_if.loc_rdata, 32'h32323232);
        serve("t8 last addr", 1'b0, 16'h0081, 32'h0, 1, 32'h81818181);
        check("t8 spi_rdata", arb_if.spi_rdata, 32'h81818181);
        repeat (3) tick();
        check("t8 one read only", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);

        // 9: spi_rd_done cancels a read that has not started
        arb_if.loc_addr = 16'h0033;
        arb_if.loc_req  = 1'b1;
        wait_strobe(found);
        check("t9 loc strobe", {31'b0, found}, 32'h1);
        strobe_addr(16'h0090);
        arb_if.spi_rd_done = 1'b1;
        tick();
        arb_if.spi_rd_done = 1'b0;
        arb_if.bus_ack     = 1'b1;
        tick();
        arb_if.bus_ack     = 1'b0;
        arb_if.loc_req     = 1'b0;
        check("t9 loc_done", {31'b0, arb_if.loc_done}, 32'h1);
        repeat (3) tick();
        check("t9 read cancelled", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);
        check("t9 spi_rdata kept", arb_if.spi_rdata, 32'h81818181);

        // 6: reset during bus_we, with a read also pending
        arb_if.spi_addr      = 16'h00A0;
        arb_if.spi_addr_rdy  = 1'b1;
        arb_if.spi_wdata     = 32'h77777777;
        arb_if.spi_wdata_rdy = 1'b1;
        tick();
        arb_if.spi_addr_rdy  = 1'b0;
        arb_if.spi_wdata_rdy = 1'b0;
        wait_strobe(found);
        check("t6 we active", {31'b0, arb_if.bus_we}, 32'h1);
        rst_n_syn = 1'b0;
        #1;
        check("t6 async strobes", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);
        check("t6 spi_rdata", arb_if.spi_rdata, 32'h0);
        check("t6 bus_addr", {16'b0, arb_if.bus_addr}, 32'h0000FFFF);
        check("t6 err_cnt", {16'b0, arb_if.err_cnt}, 32'h0);
        tick();
        rst_n_syn = 1'b1;
        repeat (3) tick();
        check("t6 pend cleared", {30'b0, arb_if.bus_we, arb_if.bus_re}, 32'h0);
        strobe_addr(16'h00B0);
        serve("t6 rd after rst", 1'b0, 16'h00B0, 32'h0, 1, 32'hB0B0B0B0);
        check("t6 spi_rdata after", arb_if.spi_rdata, 32'hB0B0B0B0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
